// File: rtl/ice40feather_top.sv
// ice40feather_top: power-on RAM self-test for an iCE40 Feather style board.
// The block fills the internal RAM with an address-derived pattern, reads it
// back and compares every word. The result is shown on the LEDs: a blinking
// green LED means PASS, a steady red LED means FAIL. An optional UART reports
// the verdict as a text message.
//
// Ports:
//   clk     - single clock; all logic runs on its rising edge
//   resetn  - asynchronous active-low reset
//   ledr_n  - red LED, active low (on steady in FAIL)
//   ledg_n  - green LED, active low (blinks in PASS)
//   ser_tx  - UART transmit, 8N1, idle high
//
// Optional feature: define ICE40FEATHER_UART_EN to send "OK\r\n" or "ER\r\n"
// once when the verdict is reached. Without it, ser_tx is tied high.
`timescale 1ns/1ps

module ice40feather_top #(
  parameter int unsigned MEM_WORDS    = 256,
  parameter int unsigned CLK_DIV      = 106,
  parameter int unsigned BLINK_DIV    = 5000,
  parameter int unsigned INJECT_FAULT = 0
) (
  input  logic clk,
  input  logic resetn,
  output logic ledr_n,
  output logic ledg_n,
  output logic ser_tx
);

  localparam int unsigned AW  = $clog2(MEM_WORDS);
  localparam int unsigned BLW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [AW-1:0]  LAST_ADDR  = AW'(MEM_WORDS - 1);
  localparam logic [BLW-1:0] BLINK_LAST = BLW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {S_INIT, S_CHECK, S_PASS, S_FAIL} state_e;

  // Test pattern: address in the upper half, its complement in the lower half,
  // scrambled so that neighbouring words differ in many bit positions.
  function automatic logic [31:0] pattern(input logic [AW-1:0] a);
    logic [15:0] i;
    i = 16'(a);
    return {i, ~i} ^ 32'hA5A5_5A5A;
  endfunction

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   cmp_addr_q, cmp_addr_d;
  logic            cmp_valid_q, cmp_valid_d;
  logic            cmp_last_q, cmp_last_d;
  logic            err_q, err_d;
  logic [BLW-1:0]  blink_q, blink_d;
  logic            ledr_q, ledr_d;
  logic            ledg_q, ledg_d;

  logic [31:0]     mem [MEM_WORDS];
  logic [31:0]     rdata_q;
  logic            mem_we_c;
  logic            mem_re_c;
  logic [31:0]     mem_wdata_c;
  logic            mismatch_c;

  // Single-port RAM, one-cycle read latency; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[addr_q] <= mem_wdata_c;
    end else if (mem_re_c) begin
      rdata_q <= mem[addr_q];
    end
  end

  // State register and control flops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_INIT;
      addr_q      <= '0;
      cmp_addr_q  <= '0;
      cmp_valid_q <= 1'b0;
      cmp_last_q  <= 1'b0;
      err_q       <= 1'b0;
      blink_q     <= '0;
      ledr_q      <= 1'b1;
      ledg_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_last_q  <= cmp_last_d;
      err_q       <= err_d;
      blink_q     <= blink_d;
      ledr_q      <= ledr_d;
      ledg_q      <= ledg_d;
    end
  end

  // Next-state logic: fill, read-back/compare, then verdict display.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cmp_addr_d  = addr_q;
    cmp_valid_d = 1'b0;
    cmp_last_d  = 1'b0;
    err_d       = err_q;
    blink_d     = blink_q;
    ledr_d      = ledr_q;
    ledg_d      = ledg_q;
    mem_we_c    = 1'b0;
    mem_re_c    = 1'b0;
    mem_wdata_c = pattern(addr_q);
    mismatch_c  = cmp_valid_q && (rdata_q != pattern(cmp_addr_q));

    // Test hook: corrupt word 0 so the read-back must fail.
    if ((INJECT_FAULT != 0) && (addr_q == '0)) begin
      mem_wdata_c = ~pattern(addr_q);
    end

    case (state_q)
      S_INIT: begin
        mem_we_c = 1'b1;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_CHECK;
        end else begin
          addr_d = addr_q + AW'(1);
        end
      end
      S_CHECK: begin
        // Reads are issued here; the returned word is compared a cycle later.
        mem_re_c    = 1'b1;
        cmp_valid_d = 1'b1;
        cmp_last_d  = (addr_q == LAST_ADDR);
        if (addr_q != LAST_ADDR) begin
          addr_d = addr_q + AW'(1);
        end
        err_d = err_q | mismatch_c;
        if (cmp_last_q) begin
          if (err_d) begin
            state_d = S_FAIL;
            ledr_d  = 1'b0;
            ledg_d  = 1'b1;
          end else begin
            state_d = S_PASS;
            ledr_d  = 1'b1;
            ledg_d  = 1'b0;
            blink_d = '0;
          end
        end
      end
      S_PASS: begin
        if (blink_q == BLINK_LAST) begin
          blink_d = '0;
          ledg_d  = ~ledg_q;
        end else begin
          blink_d = blink_q + BLW'(1);
        end
      end
      S_FAIL: begin
        ledr_d = 1'b0;
        ledg_d = 1'b1;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  assign ledr_n = ledr_q;
  assign ledg_n = ledg_q;

`ifdef ICE40FEATHER_UART_EN
  localparam int unsigned BDW = $clog2(CLK_DIV);
  localparam logic [BDW-1:0] BAUD_LAST = BDW'(CLK_DIV - 1);

  function automatic logic [7:0] msg_byte(input logic fail, input logic [1:0] idx);
    case (idx)
      2'd0:    return fail ? 8'h45 : 8'h4F;
      2'd1:    return fail ? 8'h52 : 8'h4B;
      2'd2:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  logic           uart_act_q, uart_act_d;
  logic           uart_fail_q, uart_fail_d;
  logic [BDW-1:0] baud_q, baud_d;
  logic [3:0]     bit_q, bit_d;
  logic [1:0]     byte_q, byte_d;
  logic           tx_q, tx_d;
  logic [7:0]     cur_byte_c;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      uart_act_q  <= 1'b0;
      uart_fail_q <= 1'b0;
      baud_q      <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      tx_q        <= 1'b1;
    end else begin
      uart_act_q  <= uart_act_d;
      uart_fail_q <= uart_fail_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      tx_q        <= tx_d;
    end
  end

  // Frame sequencer: bit 0 = start, bits 1..8 = data LSB first, bit 9 = stop.
  always_comb begin
    uart_act_d  = uart_act_q;
    uart_fail_d = uart_fail_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    tx_d        = tx_q;
    cur_byte_c  = msg_byte(uart_fail_q, byte_q);

    if ((state_q == S_CHECK) && ((state_d == S_PASS) || (state_d == S_FAIL))) begin
      uart_act_d  = 1'b1;
      uart_fail_d = (state_d == S_FAIL);
      baud_d      = '0;
      bit_d       = '0;
      byte_d      = '0;
      tx_d        = 1'b0;
    end else if (uart_act_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          if (byte_q == 2'd3) begin
            uart_act_d = 1'b0;
            tx_d       = 1'b1;
          end else begin
            byte_d = byte_q + 2'd1;
            bit_d  = '0;
            tx_d   = 1'b0;
          end
        end else begin
          bit_d = bit_q + 4'd1;
          tx_d  = (bit_q == 4'd8) ? 1'b1 : cur_byte_c[bit_q[2:0]];
        end
      end else begin
        baud_d = baud_q + BDW'(1);
      end
    end
  end

  assign ser_tx = tx_q;
`else
  logic unused_clk_div;
  assign unused_clk_div = ^{32'(CLK_DIV)};
  assign ser_tx = 1'b1;
`endif

endmodule

// File: tb/tb_ice40feather_top.sv
// tb_ice40feather_top: runs a fault-free and a fault-injected instance side by
// side, aborts one run mid-CHECK, then checks verdict timing, LED behaviour,
// blink period, reset response and (when enabled) the UART message bytes.
`timescale 1ns/1ps

module tb_ice40feather_top;

  localparam int unsigned N           = 256;
  localparam int unsigned BLINK       = 50;
  localparam int unsigned CDIV        = 8;
  localparam int unsigned VERDICT_MAX = 2 * N + 4;
  localparam int unsigned N_TOGGLES   = 8;

  logic clk = 1'b0;
  logic resetn;
  logic ledr_a, ledg_a, ser_a;
  logic ledr_b, ledg_b, ser_b;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc;
  int unsigned ser_viol = 0;

  int unsigned blink_q[$];
  logic [7:0]  uart_qa[$];
  logic [7:0]  uart_qb[$];

  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (ser_a !== 1'b1 || ser_b !== 1'b1) ser_viol++;
  end

  ice40feather_top #(
    .MEM_WORDS(N), .CLK_DIV(CDIV), .BLINK_DIV(BLINK), .INJECT_FAULT(0)
  ) dut_a (
    .clk(clk), .resetn(resetn), .ledr_n(ledr_a), .ledg_n(ledg_a), .ser_tx(ser_a)
  );

  ice40feather_top #(
    .MEM_WORDS(N), .CLK_DIV(CDIV), .BLINK_DIV(BLINK), .INJECT_FAULT(1)
  ) dut_b (
    .clk(clk), .resetn(resetn), .ledr_n(ledr_b), .ledg_n(ledg_b), .ser_tx(ser_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic check_reset_outputs(input string when);
    check_eq({when, "_ledr_a"}, 32'(ledr_a), 1);
    check_eq({when, "_ledg_a"}, 32'(ledg_a), 1);
    check_eq({when, "_ser_a"},  32'(ser_a),  1);
    check_eq({when, "_ledr_b"}, 32'(ledr_b), 1);
    check_eq({when, "_ledg_b"}, 32'(ledg_b), 1);
    check_eq({when, "_ser_b"},  32'(ser_b),  1);
  endtask

  function automatic logic get_ser(input int d);
    return (d == 0) ? ser_a : ser_b;
  endfunction

  // Mid-bit UART receiver; each decoded byte is compared with the queue head.
  task automatic uart_rx(input int d);
    logic [7:0] b;
    logic       sb;
    logic       stop;
    logic [7:0] e;
    forever begin
      if (d == 0) @(negedge ser_a);
      else        @(negedge ser_b);
      #(CDIV * 5 + 2);
      if (!resetn) continue;
      sb = get_ser(d);
      for (int i = 0; i < 8; i++) begin
        #(CDIV * 10);
        b[i] = get_ser(d);
      end
      #(CDIV * 10);
      stop = get_ser(d);
      check_eq("uart_start_bit", 32'(sb), 0);
      check_eq("uart_stop_bit", 32'(stop), 1);
      if (d == 0) begin
        check_eq("uart_a_byte_expected", 32'(uart_qa.size() > 0), 1);
        if (uart_qa.size() > 0) begin
          e = uart_qa.pop_front();
          check_eq("uart_a_byte", 32'(b), 32'(e));
        end
      end else begin
        check_eq("uart_b_byte_expected", 32'(uart_qb.size() > 0), 1);
        if (uart_qb.size() > 0) begin
          e = uart_qb.pop_front();
          check_eq("uart_b_byte", 32'(b), 32'(e));
        end
      end
    end
  endtask

`ifdef ICE40FEATHER_UART_EN
  initial begin
    fork
      uart_rx(0);
      uart_rx(1);
    join_none
  end
`endif

  initial begin
    int unsigned viol;
    int unsigned va;
    int unsigned vb;
    int unsigned end_cyc;
    logic        prev;

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");

    // First run is aborted at cycle 300, in the middle of CHECK.
    resetn = 1'b1;
    viol = 0;
    repeat (300) begin
      @(negedge clk);
      if (ledr_a !== 1'b1 || ledg_a !== 1'b1 || ledr_b !== 1'b1 || ledg_b !== 1'b1) viol++;
    end
    check_eq("leds_off_before_abort", viol, 0);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (2) @(negedge clk);

    // Full run after release.
`ifdef ICE40FEATHER_UART_EN
    uart_qa = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    uart_qb = '{8'h45, 8'h52, 8'h0D, 8'h0A};
`endif
    resetn = 1'b1;
    viol = 0;
    va = 0;
    vb = 0;
    for (int k = 1; k <= int'(VERDICT_MAX); k++) begin
      @(negedge clk);
      if (k <= int'(2 * N) &&
          (ledr_a !== 1'b1 || ledg_a !== 1'b1 || ledr_b !== 1'b1 || ledg_b !== 1'b1)) viol++;
      if (va == 0 && ledg_a === 1'b0) va = cyc;
      if (vb == 0 && ledr_b === 1'b0) vb = cyc;
    end
    check_eq("leds_off_init_check", viol, 0);
    check_eq("pass_verdict_reached", 32'(va != 0), 1);
    check_eq("fail_verdict_reached", 32'(vb != 0), 1);
    check_eq("pass_ledr_n", 32'(ledr_a), 1);
    check_eq("pass_ledg_n", 32'(ledg_a), 0);
    check_eq("fail_ledr_n", 32'(ledr_b), 0);
    check_eq("fail_ledg_n", 32'(ledg_b), 1);

    // Blink period on the passing instance; failing instance must stay steady.
    if (va != 0) begin
      for (int j = 1; j <= int'(N_TOGGLES); j++) blink_q.push_back(va + BLINK * j);
    end
    end_cyc = ((va != 0) ? va : cyc) + BLINK * N_TOGGLES + BLINK / 2;
    prev = ledg_a;
    viol = 0;
    while (cyc < end_cyc) begin
      @(negedge clk);
      if (ledg_a !== prev) begin
        prev = ledg_a;
        if (blink_q.size() > 0) check_eq("blink_toggle_cycle", cyc, blink_q.pop_front());
        else                    check_eq("blink_extra_toggle", cyc, 0);
      end
      if (ledr_a !== 1'b1 || ledr_b !== 1'b0 || ledg_b !== 1'b1) viol++;
    end
    check_eq("blink_missing_toggles", blink_q.size(), 0);
    check_eq("leds_steady_after_verdict", viol, 0);

`ifdef ICE40FEATHER_UART_EN
    check_eq("uart_bytes_missing", uart_qa.size() + uart_qb.size(), 0);
`else
    check_eq("ser_tx_idle_whole_run", ser_viol, 0);
`endif

    // Reset during the verdict display must clear the LEDs at once.
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("verdict_reset");
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
